// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for a 5-stage MIPS32 pipeline.
// Resolves RAW hazards on NPORT decode-stage source operands and produces
// forwarding selects. Early ports are consumed in D. Late ports are consumed
// in E. Also tracks occupancy of the multi-cycle mult/div unit.
module hazard_scoreboard #(
  parameter int NPORT   = 2,
  parameter int AW      = 5,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 34,
  parameter int CW      = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               d_valid,
  input  logic               hold,
  input  logic [NPORT*AW-1:0] src_addr_d,
  input  logic [NPORT-1:0]   src_use_d,
  input  logic [NPORT-1:0]   src_early_d,
  input  logic               md_start_d,
  input  logic               md_div_d,
  input  logic               md_use_d,
  input  logic               e_valid,
  input  logic               m_valid,
  input  logic               w_valid,
  input  logic [AW-1:0]      dst_e,
  input  logic [AW-1:0]      dst_m,
  input  logic [AW-1:0]      dst_w,
  input  logic               wen_e,
  input  logic               wen_m,
  input  logic               wen_w,
  input  logic               late_e,
  input  logic               late_m,
  output logic               stall_d,
  output logic [NPORT*2-1:0] fwd_d,
  output logic [NPORT*2-1:0] fwd_e,
  output logic               md_busy
);

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_M  = 2'd1;
  localparam logic [1:0] SEL_W  = 2'd2;

  logic [NPORT-1:0]   match_e;
  logic [NPORT-1:0]   match_m;
  logic [NPORT-1:0]   match_w;
  logic [NPORT-1:0]   port_stall;
  logic [NPORT*2-1:0] fwd_e_d;
  logic [NPORT*2-1:0] fwd_e_q;
  logic [CW-1:0]      md_cnt_d;
  logic [CW-1:0]      md_cnt_q;
  logic               md_stall;
  logic               md_issue;

  // Per-port producer matching. Register 0 is hard-wired, so it never matches.
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    logic [AW-1:0] src;
    assign src = src_addr_d[gi*AW +: AW];

    assign match_e[gi] = e_valid && wen_e && (dst_e == src) && (dst_e != '0) && src_use_d[gi];
    assign match_m[gi] = m_valid && wen_m && (dst_m == src) && (dst_m != '0) && src_use_d[gi];
    assign match_w[gi] = w_valid && wen_w && (dst_w == src) && (dst_w != '0) && src_use_d[gi];

    // An early port cannot wait for anything still in E or a late result in M.
    // A late port only waits on a late result in E (load-use).
    assign port_stall[gi] = src_early_d[gi] ? (match_e[gi] || (match_m[gi] && late_m))
                                            : (match_e[gi] && late_e);

    // D-stage select for early ports. The youngest producer (M) wins over W.
    assign fwd_d[gi*2 +: 2] = !src_early_d[gi] ? SEL_RF :
                              match_m[gi]      ? SEL_M  :
                              match_w[gi]      ? SEL_W  : SEL_RF;

    // E-stage select, precomputed one stage ahead. Producers move down one
    // stage at the same edge. A W producer is covered by the write-through regfile.
    assign fwd_e_d[gi*2 +: 2] = src_early_d[gi] ? SEL_RF :
                                match_e[gi]     ? SEL_M  :
                                match_m[gi]     ? SEL_W  : SEL_RF;
  end

  assign md_busy  = (md_cnt_q != '0);
  assign md_stall = (md_start_d || md_use_d) && md_busy;
  assign stall_d  = d_valid && ((|port_stall) || md_stall);
  assign md_issue = d_valid && md_start_d && !stall_d && !hold;
  assign fwd_e    = fwd_e_q;

  // D->E forwarding select register: load, bubble on stall, keep on hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_e_q <= '0;
    end else if (!hold) begin
      fwd_e_q <= stall_d ? '0 : fwd_e_d;
    end
  end

  // Mult/div occupancy counter: a new issue loads the counter. Otherwise it
  // counts down. The countdown ignores hold because the unit runs on its own.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_issue) begin
      md_cnt_d = md_div_d ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  // Mult/div counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_valid, hold;
  logic [9:0]  src_addr_d;
  logic [1:0]  src_use_d, src_early_d;
  logic        md_start_d, md_div_d, md_use_d;
  logic        e_valid, m_valid, w_valid;
  logic [4:0]  dst_e, dst_m, dst_w;
  logic        wen_e, wen_m, wen_w;
  logic        late_e, late_m;
  logic        stall_d;
  logic [3:0]  fwd_d, fwd_e;
  logic        md_busy;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .hold(hold),
    .src_addr_d(src_addr_d), .src_use_d(src_use_d), .src_early_d(src_early_d),
    .md_start_d(md_start_d), .md_div_d(md_div_d), .md_use_d(md_use_d),
    .e_valid(e_valid), .m_valid(m_valid), .w_valid(w_valid),
    .dst_e(dst_e), .dst_m(dst_m), .dst_w(dst_w),
    .wen_e(wen_e), .wen_m(wen_m), .wen_w(wen_w),
    .late_e(late_e), .late_m(late_m),
    .stall_d(stall_d), .fwd_d(fwd_d), .fwd_e(fwd_e), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic idle();
    d_valid = 0; src_addr_d = '0; src_use_d = '0; src_early_d = '0;
    md_start_d = 0; md_div_d = 0; md_use_d = 0;
    e_valid = 0; m_valid = 0; w_valid = 0;
    dst_e = '0; dst_m = '0; dst_w = '0;
    wen_e = 0; wen_m = 0; wen_w = 0; late_e = 0; late_m = 0;
  endtask

  // Advance one clock; inputs are driven and outputs sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; hold = 0; idle();
    step(); step();
    #1;
    check_eq("reset_fwd_e", fwd_e, 0);
    check_eq("reset_md_busy", md_busy, 0);
    check_eq("reset_stall", stall_d, 0);
    rst_n = 1;
    step();

    // 1. Load-use on a late port.
    idle(); d_valid = 1; src_addr_d = {5'd0, 5'd8}; src_use_d = 2'b01;
    e_valid = 1; wen_e = 1; late_e = 1; dst_e = 5'd8;
    #1; check_eq("loaduse_stall", stall_d, 1);
    d_valid = 0;
    #1; check_eq("loaduse_novalid", stall_d, 0);
    d_valid = 1;
    step(); check_eq("loaduse_bubble_fwd_e", fwd_e, 0);
    e_valid = 0; wen_e = 0; late_e = 0;
    m_valid = 1; wen_m = 1; late_m = 1; dst_m = 5'd8;
    #1; check_eq("loaduse_m_nostall", stall_d, 0);
    step(); check_eq("loaduse_fwd_e_w", fwd_e, 4'b0010);

    // 2. ALU chain, then hold freezes fwd_e.
    idle(); d_valid = 1; src_addr_d = {5'd3, 5'd3}; src_use_d = 2'b11;
    e_valid = 1; wen_e = 1; dst_e = 5'd3;
    #1; check_eq("alu_stall", stall_d, 0);
    step(); check_eq("alu_fwd_e", fwd_e, 4'b0101);
    idle(); d_valid = 1; hold = 1;
    for (int k = 0; k < 3; k++) begin
      step(); check_eq("hold_fwd_e", fwd_e, 4'b0101);
    end
    hold = 0;

    // 3. Branch on early ports.
    idle(); d_valid = 1; src_addr_d = {5'd6, 5'd5}; src_use_d = 2'b11; src_early_d = 2'b11;
    e_valid = 1; wen_e = 1; dst_e = 5'd5;
    #1; check_eq("branch_e_stall", stall_d, 1);
    step(); check_eq("branch_bubble_fwd_e", fwd_e, 0);
    e_valid = 0; wen_e = 0;
    m_valid = 1; wen_m = 1; dst_m = 5'd5; late_m = 0;
    w_valid = 1; wen_w = 1; dst_w = 5'd6;
    #1; check_eq("branch_stall", stall_d, 0);
    check_eq("branch_fwd_d", fwd_d, 4'b1001);
    late_m = 1;
    #1; check_eq("branch_late_m_stall", stall_d, 1);
    late_m = 0; dst_w = 5'd5;
    #1; check_eq("branch_m_over_w", fwd_d, 4'b0001);

    // 4. Register zero never matches.
    step();
    idle(); d_valid = 1; src_addr_d = '0; src_use_d = 2'b11; src_early_d = 2'b01;
    e_valid = 1; m_valid = 1; w_valid = 1; wen_e = 1; wen_m = 1; wen_w = 1;
    late_e = 1; late_m = 1;
    #1; check_eq("zero_stall", stall_d, 0);
    check_eq("zero_fwd_d", fwd_d, 0);
    step(); check_eq("zero_fwd_e", fwd_e, 0);

    // 5. Divide, then mflo waits out the whole latency.
    idle(); d_valid = 1; md_start_d = 1; md_div_d = 1;
    #1; check_eq("div_issue_stall", stall_d, 0);
    step();
    idle(); d_valid = 1; md_use_d = 1;
    for (int k = 1; k <= 34; k++) begin
      #1;
      check_eq("div_busy", md_busy, 1);
      check_eq("mflo_stall", stall_d, 1);
      step();
    end
    #1;
    check_eq("div_done_busy", md_busy, 0);
    check_eq("mflo_issue", stall_d, 0);
    step();

    // Second mult while a divide is busy: waits, then loads MUL_LAT.
    idle(); d_valid = 1; md_start_d = 1; md_div_d = 1;
    step();
    idle(); d_valid = 1; md_start_d = 1;
    n = 0; #1;
    while (stall_d && n < 60) begin n++; step(); #1; end
    check_eq("mult_wait_cycles", n, 34);
    step();
    idle(); hold = 1;
    n = 0; #1;
    while (md_busy && n < 60) begin n++; step(); #1; end
    check_eq("mult_busy_cycles", n, 5);
    d_valid = 1; md_start_d = 1;
    step(); check_eq("hold_blocks_issue", md_busy, 0);
    hold = 0;

    // 6. Asynchronous reset in the middle of a divide.
    idle(); d_valid = 1; md_start_d = 1; md_div_d = 1;
    src_addr_d = {5'd0, 5'd7}; src_use_d = 2'b01;
    e_valid = 1; wen_e = 1; dst_e = 5'd7;
    step();
    md_start_d = 0; md_div_d = 0;
    repeat (9) step();
    check_eq("pre_reset_busy", md_busy, 1);
    check_eq("pre_reset_fwd_e", fwd_e, 4'b0001);
    #2; rst_n = 0;
    #1;
    check_eq("async_reset_busy", md_busy, 0);
    check_eq("async_reset_fwd_e", fwd_e, 0);
    step(); rst_n = 1; idle();
    step(); check_eq("post_reset_busy", md_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
